// File: rtl/wb_regfile_stage.sv
// Writeback stage: sub-word load extension, writeback select, 32x32 register file
// with x0 tied to zero, two bypassed ID read ports, a debug port and a retire counter.
module wb_regfile_stage #(
  parameter int RF_DEPTH = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      RD,
  input  logic [31:0]      AluOutMW,
  input  logic [31:0]      PCMW,
  input  logic [4:0]       RdMW,
  input  logic [2:0]       RegWriteMW,
  input  logic             MemToRegMW,
  input  logic             LoadNpcMW,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  input  logic [4:0]       A3,
  output logic [31:0]      RD3,
  output logic [31:0]      ResultW,
  output logic             RegWriteW,
  output logic [CNT_W-1:0] RetireCnt
);

  localparam logic [2:0] T_LB  = 3'd1;
  localparam logic [2:0] T_LH  = 3'd2;
  localparam logic [2:0] T_LW  = 3'd3;
  localparam logic [2:0] T_LBU = 3'd4;
  localparam logic [2:0] T_LHU = 3'd5;

  logic [31:0]      rf_q [RF_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             type_ok;
  logic             rd_ok;
  logic [31:0]      ext_data;
  logic [31:0]      npc;
  logic [31:0]      st1;
  logic [31:0]      st2;

  // Halfword select ignores off[0]: misaligned halfwords are not trapped.
  function automatic logic [31:0] load_extend(input logic [2:0]  ty,
                                              input logic [31:0] word,
                                              input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (ty)
      T_LB:    r = 32'(b);
      T_LBU:   r = {24'd0, b};
      T_LH:    r = 32'(h);
      T_LHU:   r = {16'd0, h};
      T_LW:    r = word;
      default: r = word;
    endcase
    return r;
  endfunction

  assign type_ok  = (RegWriteMW >= T_LB) && (RegWriteMW <= T_LHU);
  assign rd_ok    = (RdMW != 5'd0) && (int'(RdMW) < RF_DEPTH);
  assign ext_data = load_extend(RegWriteMW, RD, AluOutMW[1:0]);
  assign npc      = PCMW + 32'd4;

  always_comb begin
    ResultW = AluOutMW;
    if (LoadNpcMW)       ResultW = npc;
    else if (MemToRegMW) ResultW = ext_data;
  end

  // Reset level gates the strobe so nothing commits or bypasses while held.
  assign RegWriteW = rst_n & en & type_ok & rd_ok;
  assign cnt_d     = cnt_q + CNT_W'(1);

  always_comb begin
    st1 = '0;
    st2 = '0;
    RD3 = '0;
    if (A1 != 5'd0 && int'(A1) < RF_DEPTH) st1 = rf_q[A1];
    if (A2 != 5'd0 && int'(A2) < RF_DEPTH) st2 = rf_q[A2];
    if (A3 != 5'd0 && int'(A3) < RF_DEPTH) RD3 = rf_q[A3];
  end

  assign RD1 = (RegWriteW && A1 == RdMW) ? ResultW : st1;
  assign RD2 = (RegWriteW && A2 == RdMW) ? ResultW : st2;

  // Commit edge: register file and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      cnt_q <= '0;
    end else if (RegWriteW) begin
      rf_q[RdMW] <= ResultW;
      cnt_q      <= cnt_d;
    end
  end

  assign RetireCnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage (retire counter narrowed to 4 bits to reach wrap).
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] RD, AluOutMW, PCMW;
  logic [4:0]  RdMW, A1, A2, A3;
  logic [2:0]  RegWriteMW;
  logic        MemToRegMW, LoadNpcMW;
  logic [31:0] RD1, RD2, RD3, ResultW;
  logic        RegWriteW;
  logic [3:0]  RetireCnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile_stage #(.RF_DEPTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .RD(RD), .AluOutMW(AluOutMW), .PCMW(PCMW),
    .RdMW(RdMW), .RegWriteMW(RegWriteMW), .MemToRegMW(MemToRegMW), .LoadNpcMW(LoadNpcMW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .A3(A3), .RD3(RD3),
    .ResultW(ResultW), .RegWriteW(RegWriteW), .RetireCnt(RetireCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    en = 1'b1; RegWriteMW = 3'd3; MemToRegMW = 1'b0; LoadNpcMW = 1'b0;
    AluOutMW = val; RdMW = rd;
    tick();
    RegWriteMW = 3'd0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; RD = '0; AluOutMW = '0; PCMW = '0;
    RdMW = 5'd5; RegWriteMW = 3'd3; MemToRegMW = 1'b0; LoadNpcMW = 1'b0;
    A1 = 5'd5; A2 = 5'd0; A3 = 5'd5;
    tick();
    chk("rst_cnt", 32'(RetireCnt), 32'd0);
    chk("rst_rd3", RD3, 32'd0);
    chk("rst_wen", 32'(RegWriteW), 32'd0);
    chk("rst_rd1", RD1, 32'd0);
    RegWriteMW = 3'd0;
    rst_n = 1'b1;

    // Preload then asynchronous reset mid-cycle
    wr(5'd5, 32'h0000_1234);
    wr(5'd1, 32'h1);
    wr(5'd2, 32'h2);
    A3 = 5'd5;
    #1;
    chk("pre_x5", RD3, 32'h0000_1234);
    chk("pre_cnt", 32'(RetireCnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_x5", RD3, 32'd0);
    chk("arst_cnt", 32'(RetireCnt), 32'd0);
    #1;
    rst_n = 1'b1;

    // Load extension (RdMW=0 so nothing commits)
    RD = 32'h80FF_7F01; RdMW = 5'd0; MemToRegMW = 1'b1; LoadNpcMW = 1'b0;
    RegWriteMW = 3'd1;
    AluOutMW = 32'h100; #1 chk("lb0", ResultW, 32'h0000_0001);
    AluOutMW = 32'h101; #1 chk("lb1", ResultW, 32'h0000_007F);
    AluOutMW = 32'h102; #1 chk("lb2", ResultW, 32'hFFFF_FFFF);
    AluOutMW = 32'h103; #1 chk("lb3", ResultW, 32'hFFFF_FF80);
    RegWriteMW = 3'd4;
    AluOutMW = 32'h103; #1 chk("lbu3", ResultW, 32'h0000_0080);
    AluOutMW = 32'h101; #1 chk("lbu1", ResultW, 32'h0000_007F);
    RegWriteMW = 3'd2;
    AluOutMW = 32'h102; #1 chk("lh2", ResultW, 32'hFFFF_80FF);
    AluOutMW = 32'h103; #1 chk("lh3", ResultW, 32'hFFFF_80FF);
    RegWriteMW = 3'd5;
    AluOutMW = 32'h100; #1 chk("lhu0", ResultW, 32'h0000_7F01);
    AluOutMW = 32'h102; #1 chk("lhu2", ResultW, 32'h0000_80FF);
    RegWriteMW = 3'd3;
    AluOutMW = 32'h101; #1 chk("lw", ResultW, 32'h80FF_7F01);
    RegWriteMW = 3'd1; MemToRegMW = 1'b0;
    AluOutMW = 32'h0000_0003; #1 chk("alu_sel", ResultW, 32'h0000_0003);

    // Select priority
    MemToRegMW = 1'b1; LoadNpcMW = 1'b1;
    PCMW = 32'h0000_0FFC; #1 chk("npc", ResultW, 32'h0000_1000);
    PCMW = 32'hFFFF_FFFC; #1 chk("npc_wrap", ResultW, 32'h0000_0000);
    LoadNpcMW = 1'b0; MemToRegMW = 1'b0; RegWriteMW = 3'd0;
    tick();

    // Bypass
    en = 1'b1; RegWriteMW = 3'd3; AluOutMW = 32'hDEAD_BEEF; RdMW = 5'd7;
    A1 = 5'd7; A2 = 5'd7; A3 = 5'd7;
    #1;
    chk("byp_wen", 32'(RegWriteW), 32'd1);
    chk("byp_rd1", RD1, 32'hDEAD_BEEF);
    chk("byp_rd2", RD2, 32'hDEAD_BEEF);
    chk("byp_rd3_pre", RD3, 32'd0);
    A2 = 5'd8; #1 chk("byp_rd2_other", RD2, 32'd0);
    tick();
    RegWriteMW = 3'd0;
    #1;
    chk("byp_rd3_post", RD3, 32'hDEAD_BEEF);
    chk("byp_rd1_post", RD1, 32'hDEAD_BEEF);
    chk("byp_cnt", 32'(RetireCnt), 32'd1);

    // Load commit through the extension path
    RD = 32'h80FF_7F01; AluOutMW = 32'h103; MemToRegMW = 1'b1; RegWriteMW = 3'd1;
    RdMW = 5'd10; A3 = 5'd10;
    tick();
    RegWriteMW = 3'd0; MemToRegMW = 1'b0;
    #1;
    chk("lb_commit", RD3, 32'hFFFF_FF80);
    chk("lb_cnt", 32'(RetireCnt), 32'd2);

    // Write to x0
    A1 = 5'd0; A3 = 5'd0;
    en = 1'b1; RegWriteMW = 3'd3; AluOutMW = 32'h55; RdMW = 5'd0;
    #1;
    chk("x0_wen", 32'(RegWriteW), 32'd0);
    chk("x0_rd1_pre", RD1, 32'd0);
    tick();
    chk("x0_rd1", RD1, 32'd0);
    chk("x0_rd3", RD3, 32'd0);
    chk("x0_cnt", 32'(RetireCnt), 32'd2);

    // Stall
    en = 1'b0; RegWriteMW = 3'd3; AluOutMW = 32'h99; RdMW = 5'd9; A1 = 5'd9; A3 = 5'd9;
    #1;
    chk("stall_wen", 32'(RegWriteW), 32'd0);
    chk("stall_res", ResultW, 32'h99);
    chk("stall_rd1", RD1, 32'd0);
    tick();
    chk("stall_x9", RD3, 32'd0);
    chk("stall_cnt", 32'(RetireCnt), 32'd2);

    // Reserved types
    en = 1'b1; RegWriteMW = 3'd6;
    #1 chk("rsv6_wen", 32'(RegWriteW), 32'd0);
    tick();
    RegWriteMW = 3'd7;
    #1 chk("rsv7_wen", 32'(RegWriteW), 32'd0);
    tick();
    RegWriteMW = 3'd0;
    chk("rsv_x9", RD3, 32'd0);
    chk("rsv_cnt", 32'(RetireCnt), 32'd2);

    // Counter wrap: 16 commits from a clean reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr(5'(i), 32'h0000_1000 + 32'(i));
      if (i == 15) chk("cnt15", 32'(RetireCnt), 32'd15);
    end
    #1;
    chk("cnt_wrap", 32'(RetireCnt), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      A3 = 5'(i);
      #1;
      chk($sformatf("wrap_x%0d", i), RD3, 32'h0000_1000 + 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
